// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type, frame constants and baud helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  function automatic int bit_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with power-of-two depth; pointers wrap naturally
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte stream to 8N1 serial transmitter with input FIFO
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_RATE     = 9600,
  parameter int CLOCK_FREQ_HZ = 12000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       TX,
  output logic       busy
);

  localparam int BIT_PERIOD = bit_period(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int CW = (BIT_PERIOD < 2) ? 1 : $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_PERIOD - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(UART_DATA_BITS - 1);

  if (BIT_PERIOD < 2) begin : g_bit_period_check
    $error("uart_tx_fifo: BIT_PERIOD must be at least 2");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cycle_cnt_q, cycle_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [7:0]           fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                 bit_end;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid && in_ready),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign in_ready = !fifo_full && !rst;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);
  assign TX       = tx_q;
  assign bit_end  = (cycle_cnt_q == LAST_CYCLE);

  // tx_d is the line level for the next cycle, so TX moves only when a bit boundary is crossed.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    fifo_pop    = 1'b0;
    if (state_q != IDLE) cycle_cnt_d = bit_end ? '0 : cycle_cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shreg_d     = fifo_data;
          cycle_cnt_d = '0;
          state_d     = START;
          tx_d        = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
          tx_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_data;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo at three baud configurations
module tb_uart_tx_fifo;

  localparam int BP_A = 1250;
  localparam int BP_B = 104;
  localparam int BP_C = 2;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  in_valid = 3'b000;
  logic [7:0]  in_data [3];
  logic [2:0]  in_ready, tx, busy;
  exp_t        q0[$], q1[$], q2[$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.BAUD_RATE(9600), .CLOCK_FREQ_HZ(12000000), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .TX(tx[0]), .busy(busy[0]));

  uart_tx_fifo #(.BAUD_RATE(115200), .CLOCK_FREQ_HZ(12000000), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .TX(tx[1]), .busy(busy[1]));

  uart_tx_fifo #(.BAUD_RATE(2), .CLOCK_FREQ_HZ(4), .FIFO_DEPTH(2)) dut_c (
    .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .TX(tx[2]), .busy(busy[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic void push_exp(input int k, input logic [7:0] b);
    exp_t e;
    e.cyc  = cyc;
    e.data = b;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop_exp(input int k, output exp_t e);
    bit ok;
    e = '0;
    case (k)
      0:       begin ok = (q0.size() != 0); if (ok) e = q0.pop_front(); end
      1:       begin ok = (q1.size() != 0); if (ok) e = q1.pop_front(); end
      default: begin ok = (q2.size() != 0); if (ok) e = q2.pop_front(); end
    endcase
    return ok;
  endfunction

  function automatic int exp_count(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void flush_exp(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic idle(input int k);
    in_valid[k] = 1'b0;
    in_data[k]  = 8'($urandom);
  endtask

  // Holds in_valid with the byte until a transfer happens; in_valid is left high.
  task automatic send(input int k, input logic [7:0] b, output int unsigned acc);
    int waited = 0;
    in_data[k]  = b;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && waited < 5000) begin
      tick();
      waited++;
    end
    chk($sformatf("accept_dut%0d", k), 32'(in_ready[k]), 32'd1);
    acc = cyc;
    if (in_ready[k]) push_exp(k, b);
    tick();
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) tick();
  endtask

  task automatic wait_idle(input int k, input int limit);
    int n = 0;
    while (busy[k] && n < limit) begin
      tick();
      n++;
    end
    chk($sformatf("drain_dut%0d", k), 32'(busy[k]), 32'd0);
  endtask

  // One-cycle reset pulse; a reset discards every queued and in-flight byte.
  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    flush_exp(k);
    tick();
    chk($sformatf("rst_tx_dut%0d", k), 32'(tx[k]), 32'd1);
    chk($sformatf("rst_busy_dut%0d", k), 32'(busy[k]), 32'd0);
    chk($sformatf("rst_ready_low_dut%0d", k), 32'(in_ready[k]), 32'd0);
    rst[k] = 1'b0;
    #1;
    chk($sformatf("rst_ready_high_dut%0d", k), 32'(in_ready[k]), 32'd1);
  endtask

  // Line receiver: each frame must start at max(previous frame end, accept cycle + 2)
  // and match the 8N1 waveform of the expected byte on every cycle.
  task automatic monitor(input int k, input int bp);
    int unsigned prev_end = 0;
    forever begin
      @(negedge clk);
      if (rst[k]) prev_end = 0;
      else if (tx[k] === 1'b0) begin
        exp_t        e;
        bit          ok;
        bit          aborted;
        int unsigned start;
        int unsigned bad;
        logic [7:0]  got;
        logic        expbit;
        int          idx;
        start   = cyc;
        bad     = 0;
        got     = '0;
        aborted = 1'b0;
        ok      = pop_exp(k, e);
        chk($sformatf("frame_expected_dut%0d", k), 32'(ok), 32'd1);
        for (int c = 0; c < 10 * bp; c++) begin
          if (c > 0) @(negedge clk);
          if (rst[k]) begin
            aborted = 1'b1;
            break;
          end
          idx    = c / bp;
          expbit = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : e.data[idx-1];
          if (tx[k] !== expbit) bad++;
          if ((c % bp) == (bp / 2) && idx >= 1 && idx <= 8) got[idx-1] = tx[k];
        end
        if (aborted) prev_end = 0;
        else begin
          if (ok) begin
            chk($sformatf("start_time_dut%0d", k), start, umax(prev_end, e.cyc + 2));
            chk($sformatf("wave_bad_cycles_dut%0d", k), bad, 32'd0);
            chk($sformatf("rx_byte_dut%0d", k), 32'(got), 32'(e.data));
          end
          prev_end = start + 10 * bp;
        end
      end
    end
  endtask

  task automatic stim_a();
    int unsigned p, acc;
    do_reset(0);
    repeat (9) tick();
    p = cyc;
    send(0, 8'h31, acc);
    idle(0);
    wait_cyc(p + 2 + 10 * BP_A - 1);
    chk("a_busy_last_stop_cycle", 32'(busy[0]), 32'd1);
    tick();
    chk("a_busy_fall", 32'(busy[0]), 32'd0);
    chk("a_tx_idle", 32'(tx[0]), 32'd1);
    tick();
    p = cyc;
    send(0, 8'h00, acc);
    idle(0);
    wait_cyc(p + 2 + 4 * BP_A + BP_A / 2);
    chk("a_tx_mid_bit3", 32'(tx[0]), 32'd0);
    do_reset(0);
    tick();
    send(0, 8'h55, acc);
    idle(0);
    wait_idle(0, 20000);
  endtask

  task automatic stim_b();
    int unsigned c0, acc;
    do_reset(1);
    repeat (3) tick();
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      send(1, 8'(8'h35 - i), acc);
      chk("b_burst_accept_cycle", acc, c0 + i);
    end
    idle(1);
    chk("b_full_ready_low", 32'(in_ready[1]), 32'd0);
    wait_cyc(c0 + 2 + 10 * BP_B - 1);
    chk("b_ready_low_frame0", 32'(in_ready[1]), 32'd0);
    tick();
    chk("b_ready_after_frame0", 32'(in_ready[1]), 32'd1);
    wait_cyc(c0 + 2 + 50 * BP_B - 1);
    chk("b_busy_last_stop", 32'(busy[1]), 32'd1);
    tick();
    chk("b_busy_after_burst", 32'(busy[1]), 32'd0);

    tick();
    c0 = cyc;
    for (int i = 0; i < 5; i++) send(1, 8'($urandom), acc);
    send(1, 8'hA5, acc);
    idle(1);
    chk("b_stall_accept_cycle", acc, c0 + 2 + 10 * BP_B);
    wait_idle(1, 10000);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        idle(1);
        tick();
      end
      send(1, 8'($urandom), acc);
    end
    idle(1);
    wait_idle(1, 10000);
  endtask

  task automatic stim_c();
    int unsigned c0, acc;
    do_reset(2);
    repeat (2) tick();
    c0 = cyc;
    send(2, 8'hFF, acc);
    send(2, 8'h00, acc);
    idle(2);
    chk("c_second_accept_cycle", acc, c0 + 1);
    wait_cyc(c0 + 2 + 9 * BP_C);
    chk("c_stop_first_cycle", 32'(tx[2]), 32'd1);
    tick();
    chk("c_stop_second_cycle", 32'(tx[2]), 32'd1);
    tick();
    chk("c_next_start_bit", 32'(tx[2]), 32'd0);
    wait_idle(2, 200);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) begin
        idle(2);
        tick();
      end
      send(2, 8'($urandom), acc);
    end
    idle(2);
    wait_idle(2, 200);
  endtask

  initial monitor(0, BP_A);
  initial monitor(1, BP_B);
  initial monitor(2, BP_C);

  initial begin
    for (int i = 0; i < 3; i++) in_data[i] = 8'h00;
    fork
      begin
        fork
          stim_a();
          stim_b();
          stim_c();
        join
      end
      begin
        repeat (95000) @(posedge clk);
        n_chk++;
        n_fail++;
        $display("FAIL global_timeout: reached cycle %0d, expected all stimulus done before 95000", cyc);
      end
    join_any
    chk("queue_empty_dut0", exp_count(0), 32'd0);
    chk("queue_empty_dut1", exp_count(1), 32'd0);
    chk("queue_empty_dut2", exp_count(2), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
